cpld_bank_ctrl: RTL and testbench

CPLD_BANK_CTRL -- requirements
Module: cpld_bank_ctrl

---
 rtl/cpld_bank_pkg.sv | 30 +++
 rtl/cpld_estrobe_sync.sv | 43 ++++
 rtl/cpld_bank_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_cpld_bank_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpld_bank_pkg.sv
// -----------------------------------------------------------------------------
// cpld_bank_pkg
// Shared definitions for the 6809 memory-banking CPLD:
//   - register block offsets and CTRL bit positions
//   - wait-state FSM state encoding
//   - register-block address decode helper
// Optional feature macro used by the top: BANK_READBACK_EN.
// -----------------------------------------------------------------------------
package cpld_bank_pkg;

  // Offset of the control register inside the 16-byte register block.
  localparam logic [3:0] OFS_CTRL = 4'd15;

  // CTRL layout: bit0 = MAP_EN, bits[WAIT_W:1] = WAITS.
  localparam int CTRL_MAP_EN_BIT = 0;
  localparam int CTRL_WAITS_LSB  = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_HOLD    = 2'd2
  } wait_state_e;

  // True when the address falls inside the 16-byte register block at base.
  // Only the upper twelve bits take part in the match.
  function automatic logic reg_hit(input logic [15:0] a, input logic [15:0] base);
    return ((a ^ base) & 16'hFFF0) == 16'h0000;
  endfunction

endpackage

// File: rtl/cpld_estrobe_sync.sv
// -----------------------------------------------------------------------------
// cpld_estrobe_sync
// Brings the asynchronous 6809 E strobe into the clk domain through two flops
// and produces single-cycle rise/fall pulses from the synchronised level.
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_e_async  raw E strobe
//   o_e_sync   synchronised E level
//   o_e_rise   one-cycle pulse in the first cycle o_e_sync is high
//   o_e_fall   one-cycle pulse in the first cycle o_e_sync is low again
// -----------------------------------------------------------------------------
module cpld_estrobe_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_e_async,
  output logic o_e_sync,
  output logic o_e_rise,
  output logic o_e_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_e_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_e_sync = r_sync;
  assign o_e_rise = r_sync & ~r_prev;
  assign o_e_fall = ~r_sync & r_prev;

endmodule

// File: rtl/cpld_bank_ctrl.sv
// -----------------------------------------------------------------------------
// cpld_bank_ctrl
// Memory-banking and wait-state controller for a 6809 system. The 64K CPU
// space is split into NWIN windows; each window can be remapped to any
// physical page through a page register. A 16-byte register block at REG_BASE
// holds the page registers (offsets 0..NWIN-1) and CTRL (offset 15:
// bit0 MAP_EN, bits[WAIT_W:1] WAITS). RAM accesses can be stretched by WAITS
// clk cycles through MRDY.
// Optional feature: define BANK_READBACK_EN to make the register block
// readable over dout/dout_en; otherwise the registers are write-only.
// Ports:
//   clk       system clock (>= 4x E)
//   reset_b   asynchronous active-low reset
//   e_clk     6809 E strobe (asynchronous)
//   adr       CPU address
//   rnw       CPU read-not-write
//   din       CPU write data
//   dout      register read data
//   dout_en   data bus drive enable
//   ram_page  physical page replacing the window-index address bits
//   ramcs_b   RAM chip select, active low
//   ramoe_b   RAM output enable, active low
//   ramwe_b   RAM write enable, active low
//   mrdy      6809 MRDY, low stretches E
// -----------------------------------------------------------------------------
module cpld_bank_ctrl
  import cpld_bank_pkg::*;
#(
  parameter int          NWIN     = 4,
  parameter int          PAGE_W   = 6,
  parameter int          WAIT_W   = 2,
  parameter logic [15:0] REG_BASE = 16'hFE00
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              e_clk,
  input  logic [15:0]       adr,
  input  logic              rnw,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              dout_en,
  output logic [PAGE_W-1:0] ram_page,
  output logic              ramcs_b,
  output logic              ramoe_b,
  output logic              ramwe_b,
  output logic              mrdy
);

  localparam int IDX_W  = $clog2(NWIN);
  localparam int CTRL_W = WAIT_W + 1;

  // E strobe in the clk domain.
  logic w_e_sync;
  logic w_e_rise;
  logic w_e_fall;

  cpld_estrobe_sync u_estrobe_sync (
    .i_clk     (clk),
    .i_rst_n   (reset_b),
    .i_e_async (e_clk),
    .o_e_sync  (w_e_sync),
    .o_e_rise  (w_e_rise),
    .o_e_fall  (w_e_fall)
  );

  // Address decode.
  logic             w_is_reg;
  logic             w_is_ram;
  logic [3:0]       w_ofs;
  logic [IDX_W-1:0] w_win;

  assign w_is_reg = reg_hit(adr, REG_BASE);
  assign w_is_ram = ~w_is_reg;
  assign w_ofs    = adr[3:0];
  assign w_win    = adr[15 -: IDX_W];

  // Register file.
  logic [PAGE_W-1:0] r_page [NWIN];
  logic [CTRL_W-1:0] r_ctrl;
  logic              w_map_en;
  logic [WAIT_W-1:0] w_waits;
  logic              w_wr;

  assign w_map_en = r_ctrl[CTRL_MAP_EN_BIT];
  assign w_waits  = r_ctrl[WAIT_W:CTRL_WAITS_LSB];
  // The CPU has had the whole E-high phase to settle address and data, so the
  // write lands on the edge right after the synchronised falling edge.
  assign w_wr     = w_e_fall & ~rnw & w_is_reg;

  // Page and CTRL registers; pages reset to the identity mapping.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NWIN; i++) begin
        r_page[i] <= PAGE_W'(i);
      end
      r_ctrl <= {CTRL_W{1'b0}};
    end else if (w_wr) begin
      for (int i = 0; i < NWIN; i++) begin
        if (w_ofs == 4'(i)) begin
          r_page[i] <= PAGE_W'(din);
        end
      end
      if (w_ofs == OFS_CTRL) begin
        r_ctrl <= CTRL_W'(din);
      end
    end
  end

  // Physical page selection: page register when mapping is on, else identity.
  always_comb begin
    ram_page = PAGE_W'(w_win);
    if (w_map_en) begin
      ram_page = r_page[w_win];
    end else begin
      ram_page = PAGE_W'(w_win);
    end
  end

  // RAM strobes follow the synchronised E; register accesses never select RAM.
  assign ramcs_b = ~(w_is_ram & w_e_sync);
  assign ramoe_b = ~(w_is_ram & w_e_sync & rnw);
  assign ramwe_b = ~(w_is_ram & w_e_sync & ~rnw);

  // Wait-state FSM.
  wait_state_e       r_state;
  wait_state_e       w_state_nxt;
  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W-1:0] w_cnt_nxt;
  logic              r_mrdy;
  logic              w_mrdy_nxt;

  // FSM state, counter and registered MRDY.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= ST_IDLE;
      r_cnt   <= {WAIT_W{1'b0}};
      r_mrdy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mrdy  <= w_mrdy_nxt;
    end
  end

  // Next-state logic. The count is sampled from CTRL only when a stretch
  // starts, so a CTRL change takes effect on the following stretch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mrdy_nxt  = r_mrdy;
    case (r_state)
      ST_IDLE: begin
        if (w_e_rise && w_is_ram && (w_waits != {WAIT_W{1'b0}})) begin
          w_state_nxt = ST_STRETCH;
          w_cnt_nxt   = w_waits;
          w_mrdy_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_mrdy_nxt  = 1'b1;
        end
      end
      ST_STRETCH: begin
        // Counter is never loaded with 0, so plain wrap-around is harmless.
        w_cnt_nxt = r_cnt - WAIT_W'(1);
        if (r_cnt == WAIT_W'(1)) begin
          w_state_nxt = ST_HOLD;
          w_mrdy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_STRETCH;
          w_mrdy_nxt  = 1'b0;
        end
      end
      ST_HOLD: begin
        w_mrdy_nxt = 1'b1;
        if (w_e_fall) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {WAIT_W{1'b0}};
        w_mrdy_nxt  = 1'b1;
      end
    endcase
  end

  assign mrdy = r_mrdy;

`ifdef BANK_READBACK_EN
  logic [7:0] w_rd_data;
  logic       w_dout_en;

  // Read mux over the register block; unmapped offsets read as zero.
  always_comb begin
    w_rd_data = 8'h00;
    if (w_ofs == OFS_CTRL) begin
      w_rd_data = 8'(r_ctrl);
    end else if (int'(w_ofs) < NWIN) begin
      w_rd_data = 8'(r_page[w_ofs[IDX_W-1:0]]);
    end else begin
      w_rd_data = 8'h00;
    end
  end

  assign w_dout_en = w_e_sync & rnw & w_is_reg;
  assign dout_en   = w_dout_en;
  assign dout      = w_dout_en ? w_rd_data : 8'h00;
`else
  assign dout_en = 1'b0;
  assign dout    = 8'h00;
`endif

endmodule

// File: tb/tb_cpld_bank_ctrl.sv
module tb_cpld_bank_ctrl;

  localparam int          NWIN     = 4;
  localparam int          PAGE_W   = 6;
  localparam int          WAIT_W   = 2;
  localparam logic [15:0] REG_BASE = 16'hFE00;
  localparam int          E_HIGH   = 6;
  localparam int          E_BOUND  = 64;

  logic              clk     = 1'b0;
  logic              reset_b = 1'b0;
  logic              e_clk   = 1'b0;
  logic [15:0]       adr     = 16'h0000;
  logic              rnw     = 1'b1;
  logic [7:0]        din     = 8'h00;
  logic [7:0]        dout;
  logic              dout_en;
  logic [PAGE_W-1:0] ram_page;
  logic              ramcs_b;
  logic              ramoe_b;
  logic              ramwe_b;
  logic              mrdy;

  int checks = 0;
  int errors = 0;

  cpld_bank_ctrl #(
    .NWIN     (NWIN),
    .PAGE_W   (PAGE_W),
    .WAIT_W   (WAIT_W),
    .REG_BASE (REG_BASE)
  ) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .e_clk    (e_clk),
    .adr      (adr),
    .rnw      (rnw),
    .din      (din),
    .dout     (dout),
    .dout_en  (dout_en),
    .ram_page (ram_page),
    .ramcs_b  (ramcs_b),
    .ramoe_b  (ramoe_b),
    .ramwe_b  (ramwe_b),
    .mrdy     (mrdy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (register block contents) -------------
  int page_m [NWIN];
  int ctrl_m;

  task automatic m_reset();
    for (int i = 0; i < NWIN; i++) page_m[i] = i;
    ctrl_m = 0;
  endtask

  function automatic bit m_is_reg(input int a);
    return (a / 16) == (int'(REG_BASE) / 16);
  endfunction

  function automatic int m_page(input int a);
    int w;
    w = a / (65536 / NWIN);
    return (ctrl_m % 2 == 1) ? page_m[w] : w;
  endfunction

  function automatic int m_waits(input int a);
    return m_is_reg(a) ? 0 : ctrl_m / 2;
  endfunction

  function automatic int m_read(input int a);
    int o;
    o = a % 16;
    if (o == 15) return ctrl_m;
    if (o < NWIN) return page_m[o];
    return 0;
  endfunction

  task automatic m_write(input int a, input int d);
    int o;
    o = a % 16;
    if (m_is_reg(a)) begin
      if (o < NWIN) page_m[o] = d % (1 << PAGE_W);
      else if (o == 15) ctrl_m = d % (1 << (WAIT_W + 1));
    end
  endtask

  // ---------------- bus cycle with observation gathering -------------------
  int                obs_cs_low, obs_first_cs, obs_page_unstable, obs_strobe_bad;
  int                obs_mrdy_low, obs_first_mrdy, obs_last_mrdy, obs_mrdy_after_fall;
  int                obs_dout_en_cnt, obs_dout_bad;
  bit                obs_timeout;
  logic [PAGE_W-1:0] obs_page;
  logic [7:0]        obs_dout;

  task automatic sample_obs(input int idx, input bit e_low);
    if (ramcs_b === 1'b0) begin
      if (obs_cs_low == 0) begin
        obs_first_cs = idx;
        obs_page     = ram_page;
      end else if (ram_page !== obs_page) begin
        obs_page_unstable++;
      end
      obs_cs_low++;
      if (ramoe_b !== ~rnw || ramwe_b !== rnw) obs_strobe_bad++;
    end else if (ramoe_b !== 1'b1 || ramwe_b !== 1'b1) begin
      obs_strobe_bad++;
    end
    if (mrdy !== 1'b1) begin
      if (obs_mrdy_low == 0) obs_first_mrdy = idx;
      obs_last_mrdy = idx;
      obs_mrdy_low++;
      if (e_low) obs_mrdy_after_fall++;
    end
    if (dout_en === 1'b1) begin
      if (obs_dout_en_cnt == 0) obs_dout = dout;
      obs_dout_en_cnt++;
    end else if (dout_en !== 1'b0 || dout !== 8'h00) begin
      obs_dout_bad++;
    end
  endtask

  // CPU-like cycle: E held high for E_HIGH clocks and extended while MRDY=0.
  task automatic bus_cycle(input logic [15:0] a, input logic r, input logic [7:0] d);
    int  idx;
    bit  released;
    obs_cs_low = 0; obs_first_cs = -1; obs_page_unstable = 0; obs_strobe_bad = 0;
    obs_mrdy_low = 0; obs_first_mrdy = -1; obs_last_mrdy = -1; obs_mrdy_after_fall = 0;
    obs_dout_en_cnt = 0; obs_dout_bad = 0; obs_timeout = 1'b0;
    obs_page = '0; obs_dout = 8'h00;
    @(negedge clk);
    adr = a; rnw = r; din = d; e_clk = 1'b0;
    @(negedge clk);
    e_clk    = 1'b1;
    idx      = 0;
    released = 1'b0;
    for (int k = 0; k < E_BOUND; k++) begin
      @(negedge clk);
      sample_obs(idx, 1'b0);
      idx++;
      if (k >= E_HIGH && mrdy === 1'b1) begin
        released = 1'b1;
        break;
      end
    end
    obs_timeout = !released;
    e_clk = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      sample_obs(idx, 1'b1);
      idx++;
    end
  endtask

  task automatic reg_write(input int ofs, input int d);
    bus_cycle(REG_BASE + 16'(ofs), 1'b0, 8'(d));
    m_write(int'(REG_BASE) + ofs, d);
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    reset_b = 1'b0; adr = 16'h4123; rnw = 1'b1; e_clk = 1'b0; din = 8'h00;
    m_reset();
    repeat (2) @(negedge clk);
    checks++; if (mrdy !== 1'b1) begin errors++; $display("FAIL reset_mrdy: got %b want 1", mrdy); end
    checks++; if ({ramcs_b, ramoe_b, ramwe_b} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b want 111", {ramcs_b, ramoe_b, ramwe_b}); end
    checks++; if (dout !== 8'h00 || dout_en !== 1'b0) begin errors++; $display("FAIL reset_dout: got %h/%b want 00/0", dout, dout_en); end
    checks++; if (ram_page !== PAGE_W'(1)) begin errors++; $display("FAIL reset_page: got %h want 1", ram_page); end
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_identity();
    bus_cycle(16'h4123, 1'b1, 8'h00);
    checks++; if (obs_cs_low == 0) begin errors++; $display("FAIL ident_cs: cs-low cycles %0d want >0", obs_cs_low); end
    checks++; if (obs_page !== PAGE_W'(1)) begin errors++; $display("FAIL ident_page: got %h want 1", obs_page); end
    checks++; if (obs_mrdy_low != 0) begin errors++; $display("FAIL ident_mrdy: low cycles %0d want 0", obs_mrdy_low); end
    checks++; if (obs_strobe_bad != 0) begin errors++; $display("FAIL ident_strobe: bad cycles %0d want 0", obs_strobe_bad); end
  endtask

  task automatic test_map();
    reg_write(2, 8'h2A);
    reg_write(15, 8'h01);
    bus_cycle(16'h8000, 1'b0, 8'h55);
    checks++; if (obs_page !== PAGE_W'(m_page(16'h8000)) || obs_page !== PAGE_W'(8'h2A)) begin errors++; $display("FAIL map_page: got %h want 2a", obs_page); end
    checks++; if (obs_strobe_bad != 0 || obs_cs_low == 0) begin errors++; $display("FAIL map_write_strobe: bad %0d cs %0d want 0/>0", obs_strobe_bad, obs_cs_low); end
    checks++; if (obs_page_unstable != 0) begin errors++; $display("FAIL map_stable: changes %0d want 0", obs_page_unstable); end
  endtask

  task automatic test_waits();
    reg_write(15, 8'h07);
    for (int rep = 0; rep < 2; rep++) begin
      bus_cycle(16'h1234, 1'b1, 8'h00);
      checks++; if (obs_mrdy_low != 3) begin errors++; $display("FAIL wait_count%0d: got %0d want 3", rep, obs_mrdy_low); end
      checks++; if (obs_first_mrdy != obs_first_cs + 1) begin errors++; $display("FAIL wait_start%0d: got %0d want %0d", rep, obs_first_mrdy, obs_first_cs + 1); end
      checks++; if (obs_last_mrdy - obs_first_mrdy + 1 != 3) begin errors++; $display("FAIL wait_contig%0d: span %0d want 3", rep, obs_last_mrdy - obs_first_mrdy + 1); end
      checks++; if (obs_mrdy_after_fall != 0 || obs_timeout) begin errors++; $display("FAIL wait_release%0d: late %0d timeout %0d want 0/0", rep, obs_mrdy_after_fall, obs_timeout); end
    end
  endtask

  task automatic test_reg_access();
    bus_cycle(REG_BASE + 16'd1, 1'b1, 8'h00);
    checks++; if (obs_mrdy_low != 0) begin errors++; $display("FAIL regacc_mrdy: low cycles %0d want 0", obs_mrdy_low); end
    checks++; if (obs_cs_low != 0 || obs_strobe_bad != 0) begin errors++; $display("FAIL regacc_cs: cs %0d bad %0d want 0/0", obs_cs_low, obs_strobe_bad); end
  endtask

  task automatic test_readback();
    bus_cycle(REG_BASE + 16'd2, 1'b1, 8'h00);
`ifdef BANK_READBACK_EN
    checks++; if (obs_dout_en_cnt == 0 || obs_dout !== 8'h2A) begin errors++; $display("FAIL rb_page2: en %0d dout %h want >0/2a", obs_dout_en_cnt, obs_dout); end
    bus_cycle(REG_BASE + 16'd15, 1'b1, 8'h00);
    checks++; if (obs_dout !== 8'(m_read(16'hFE0F))) begin errors++; $display("FAIL rb_ctrl: got %h want %h", obs_dout, 8'(m_read(16'hFE0F))); end
`else
    checks++; if (obs_dout_en_cnt != 0) begin errors++; $display("FAIL rb_disabled: dout_en cycles %0d want 0", obs_dout_en_cnt); end
`endif
    checks++; if (obs_dout_bad != 0) begin errors++; $display("FAIL rb_idle: bad cycles %0d want 0", obs_dout_bad); end
  endtask

  task automatic test_random();
    int          sel, a, ofs, exp_page, exp_waits, exp_rd;
    bit          exp_reg;
    logic        r;
    logic [7:0]  d;
    int          ofs_tab [6];
    ofs_tab = '{0, 1, 2, 3, 15, 5};
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        ofs = ofs_tab[$urandom_range(0, 5)];
        a   = int'(REG_BASE) + ofs;
      end else begin
        a = $urandom_range(0, 65535);
      end
      r         = 1'($urandom_range(0, 1));
      d         = 8'($urandom_range(0, 255));
      exp_reg   = m_is_reg(a);
      exp_page  = m_page(a);
      exp_waits = m_waits(a);
      exp_rd    = m_read(a);
      bus_cycle(16'(a), r, d);
      checks++; if ((obs_cs_low > 0) == exp_reg) begin errors++; $display("FAIL rnd_cs[%0d]: adr %h cs cycles %0d reg %0d", it, a, obs_cs_low, exp_reg); end
      if (!exp_reg) begin
        checks++; if (obs_page !== PAGE_W'(exp_page)) begin errors++; $display("FAIL rnd_page[%0d]: adr %h got %h want %h", it, a, obs_page, exp_page); end
      end
      checks++; if (obs_mrdy_low != exp_waits) begin errors++; $display("FAIL rnd_waits[%0d]: adr %h got %0d want %0d", it, a, obs_mrdy_low, exp_waits); end
      checks++; if (obs_strobe_bad != 0 || obs_timeout) begin errors++; $display("FAIL rnd_strobe[%0d]: bad %0d timeout %0d want 0/0", it, obs_strobe_bad, obs_timeout); end
`ifdef BANK_READBACK_EN
      if (exp_reg && r) begin
        checks++; if (obs_dout_en_cnt == 0 || obs_dout !== 8'(exp_rd)) begin errors++; $display("FAIL rnd_rb[%0d]: adr %h got %h want %h", it, a, obs_dout, exp_rd); end
      end
`else
      checks++; if (obs_dout_en_cnt != 0) begin errors++; $display("FAIL rnd_rb_off[%0d]: dout_en cycles %0d want 0 (rd %0d)", it, obs_dout_en_cnt, exp_rd); end
`endif
      if (!r) m_write(a, int'(d));
    end
  endtask

  task automatic test_reset_mid_stretch();
    bit seen;
    int lows;
    reg_write(1, 8'h33);
    reg_write(3, 8'h15);
    reg_write(15, 8'h07);
    @(negedge clk);
    adr = 16'hC000; rnw = 1'b1; e_clk = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mrdy === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_stretch_start: mrdy %b never low", mrdy); end
    #2 reset_b = 1'b0;
    #1;
    checks++; if (mrdy !== 1'b1 || ramcs_b !== 1'b1) begin errors++; $display("FAIL rst_async: mrdy %b cs %b want 1/1", mrdy, ramcs_b); end
    m_reset();
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mrdy !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL rst_no_resume: low cycles %0d want 0", lows); end
    e_clk = 1'b0;
    repeat (4) @(negedge clk);
    bus_cycle(16'h4000, 1'b1, 8'h00);
    checks++; if (obs_mrdy_low != 0 || obs_page !== PAGE_W'(m_page(16'h4000))) begin errors++; $display("FAIL rst_ctrl0: mrdy-low %0d page %h want 0/1", obs_mrdy_low, obs_page); end
    reg_write(15, 8'h01);
    bus_cycle(16'hC000, 1'b1, 8'h00);
    checks++; if (obs_page !== PAGE_W'(3)) begin errors++; $display("FAIL rst_page3: got %h want 3", obs_page); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_map();
    test_waits();
    test_reg_access();
    test_readback();
    test_random();
    test_reset_mid_stretch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
